// File: rtl/ioctl_upload_responder.sv
// ioctl_upload_responder
// Answers hps_io upload byte reads for one ioctl_index by fetching bytes from
// core RAM, holding hps_io off with ioctl_wait while the RAM read is pending.
// Reads beyond SIZE return 8'hFF without touching RAM; a RAM read that never
// acknowledges is abandoned after TIMEOUT cycles and flagged on the sticky err.
// Optional feature: define UPLOAD_DIRTY_TRACK_EN to compile in write-dirty
// tracking that raises a one-cycle upload_req (autosave) when the OSD opens.
module ioctl_upload_responder #(
  parameter logic [7:0] INDEX   = 8'd5,
  parameter int         AW      = 13,
  parameter int         SIZE    = 8192,
  parameter int         TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic          ram_ack,
  input  logic [7:0]    ram_data,
  input  logic          ram_wr_mon,
  input  logic          osd_open,
  output logic          pause_req,
  output logic          upload_req,
  output logic          err
);

  // Timeout counter only needs to reach TIMEOUT-1 (the last waiting cycle).
  localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [24:0]     SIZE_L  = 25'(SIZE);

  typedef enum logic [1:0] {IDLE, ARMED, FETCH, DONE} state_t;

  state_t          state_q, state_d;
  logic            sel, sel_q;
  logic [7:0]      din_q, din_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [15:0]     served_q, served_d;

  assign sel = ioctl_upload && (ioctl_index == INDEX);

  // ioctl_wait and ram_rd are both high exactly while a fetch is outstanding.
  assign ioctl_wait = (state_q == FETCH);
  assign ram_rd     = (state_q == FETCH);
  assign ioctl_din  = din_q;
  assign ram_addr   = addr_q;
  assign pause_req  = sel_q;
  assign err        = err_q;

  // Next-state and datapath decisions; losing sel overrides everything.
  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    served_d = served_q;
    if (!sel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!sel_q) begin
            state_d  = ARMED;
            served_d = '0;
          end
        end
        ARMED: begin
          if (ioctl_rd) begin
            if (ioctl_addr < SIZE_L) begin
              addr_d  = ioctl_addr[AW-1:0];
              cnt_d   = '0;
              state_d = FETCH;
            end else begin
              din_d = 8'hFF;
            end
          end
        end
        FETCH: begin
          if (ram_ack) begin
            din_d   = ram_data;
            state_d = DONE;
          end else if (cnt_q == TO_LAST) begin
            din_d   = 8'h00;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = ARMED;
          if (served_q != 16'hFFFF) served_d = served_q + 16'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      din_q    <= 8'h00;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel;
      din_q    <= din_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      served_q <= served_d;
    end
  end

`ifdef UPLOAD_DIRTY_TRACK_EN
  logic dirty_q, osd_q, upload_q;

  assign upload_req = upload_q;

  // Track core writes since the last upload and request an autosave on OSD open.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dirty_q  <= 1'b0;
      osd_q    <= 1'b0;
      upload_q <= 1'b0;
    end else begin
      osd_q    <= osd_open;
      upload_q <= osd_open && !osd_q && dirty_q && !sel;
      if (ram_wr_mon)
        dirty_q <= 1'b1;
      else if (sel_q && !sel && (served_q != 16'd0))
        dirty_q <= 1'b0;
    end
  end
`else
  logic unused_dirty_inputs;

  assign upload_req          = 1'b0;
  assign unused_dirty_inputs = &{1'b0, ram_wr_mon, osd_open};
`endif

endmodule

// File: tb/tb_ioctl_upload_responder.sv
// Testbench for ioctl_upload_responder: scoreboard of expected ioctl_din bytes
// pushed as each read is issued and popped when the read completes.
module tb_ioctl_upload_responder;
  localparam int AW   = 13;
  localparam int SIZE = 8192;
  localparam int TO   = 255;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic          ram_ack;
  logic [7:0]    ram_data;
  logic          ram_wr_mon;
  logic          osd_open;
  logic          pause_req;
  logic          upload_req;
  logic          err;

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_responder #(
    .INDEX(8'd5), .AW(AW), .SIZE(SIZE), .TIMEOUT(TO)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .ram_addr(ram_addr),
    .ram_rd(ram_rd), .ram_ack(ram_ack), .ram_data(ram_data),
    .ram_wr_mon(ram_wr_mon), .osd_open(osd_open), .pause_req(pause_req),
    .upload_req(upload_req), .err(err)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_din"}, ioctl_din, 8'h00);
    check({tag, "_wait"}, ioctl_wait, 1'b0);
    check({tag, "_ram_rd"}, ram_rd, 1'b0);
    check({tag, "_ram_addr"}, ram_addr, '0);
    check({tag, "_pause"}, pause_req, 1'b0);
    check({tag, "_upload_req"}, upload_req, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  // ack_dly > 0: RAM acknowledges so ioctl_wait stays high ack_dly cycles;
  // ack_dly <= 0: RAM never acknowledges (timeout path).
  task automatic read_txn(input logic [24:0] a, input int ack_dly,
                          input logic [7:0] d, input bit rd_in_done);
    int         cyc;
    int         exp_cyc;
    logic [7:0] e;
    if (a >= 25'(SIZE)) begin
      exp_q.push_back(8'hFF);
      exp_cyc = 0;
    end else if (ack_dly <= 0) begin
      exp_q.push_back(8'h00);
      exp_cyc = TO;
    end else begin
      exp_q.push_back(d);
      exp_cyc = ack_dly;
    end
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    if (a < 25'(SIZE)) begin
      check("start_ram_rd", ram_rd, 1'b1);
      check("start_wait", ioctl_wait, 1'b1);
      check("start_ram_addr", ram_addr, a[AW-1:0]);
    end else begin
      check("oor_ram_rd", ram_rd, 1'b0);
      check("oor_wait", ioctl_wait, 1'b0);
    end
    cyc = 0;
    while (ioctl_wait && cyc < TO + 10) begin
      if (ack_dly > 0 && cyc == ack_dly - 1) begin
        ram_ack  = 1'b1;
        ram_data = d;
      end
      tick();
      ram_ack = 1'b0;
      cyc++;
    end
    check("wait_cycles", cyc, exp_cyc);
    e = exp_q.pop_front();
    check("din", ioctl_din, e);
    check("end_ram_rd", ram_rd, 1'b0);
    if (rd_in_done) begin
      ioctl_addr = 25'(SIZE);
      ioctl_rd   = 1'b1;
    end
    tick();
    ioctl_rd = 1'b0;
    check("din_hold", ioctl_din, e);
    check("idle_wait", ioctl_wait, 1'b0);
    last_din = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd5;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    ram_ack      = 1'b0;
    ram_data     = 8'h00;
    ram_wr_mon   = 1'b0;
    osd_open     = 1'b0;
    last_din     = 8'h00;
    repeat (2) tick();
    check_reset_vals("rst");

    reset        = 1'b0;
    ioctl_upload = 1'b1;
    tick();
    check("pause_on", pause_req, 1'b1);

    read_txn(25'h0010, 3, 8'hA5, 1'b0);
    read_txn(25'h1FFF, 1, 8'h3C, 1'b1);
    read_txn(25'h0000, 5, 8'h5A, 1'b0);
    read_txn(25'(SIZE), 0, 8'h00, 1'b0);
    read_txn(25'h1FFFFFF, 0, 8'h00, 1'b0);

    // Stray acknowledge while ARMED must not touch ioctl_din.
    ram_ack  = 1'b1;
    ram_data = 8'h77;
    tick();
    ram_ack = 1'b0;
    check("stray_ack_din", ioctl_din, 8'hFF);
    check("stray_ack_ram_rd", ram_rd, 1'b0);

    check("err_clear", err, 1'b0);
    read_txn(25'h0040, 0, 8'h00, 1'b0);
    check("err_set", err, 1'b1);
    read_txn(25'h0041, 2, 8'hC3, 1'b0);
    check("err_sticky", err, 1'b1);

    // Another index: block stays silent.
    ioctl_index = 8'd4;
    tick();
    check("idx4_pause", pause_req, 1'b0);
    ioctl_addr = 25'h0010;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("idx4_ram_rd", ram_rd, 1'b0);
    check("idx4_wait", ioctl_wait, 1'b0);
    tick();
    check("idx4_din", ioctl_din, last_din);
    ioctl_index = 8'd5;
    tick();
    check("idx5_pause", pause_req, 1'b1);

    // Upload dropped mid-fetch aborts the read.
    ioctl_addr = 25'h0030;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("abort_start_wait", ioctl_wait, 1'b1);
    ioctl_upload = 1'b0;
    tick();
    check("abort_ram_rd", ram_rd, 1'b0);
    check("abort_wait", ioctl_wait, 1'b0);
    check("abort_din", ioctl_din, last_din);
    check("abort_err", err, 1'b1);
    ioctl_upload = 1'b1;
    tick();

    // Reset in the middle of a fetch, with an ack on the same edge.
    ioctl_addr = 25'h0050;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("rstf_ram_rd", ram_rd, 1'b1);
    reset    = 1'b1;
    ram_ack  = 1'b1;
    ram_data = 8'h99;
    tick();
    reset   = 1'b0;
    ram_ack = 1'b0;
    check_reset_vals("rstf");
    tick();
    ram_ack  = 1'b1;
    ram_data = 8'h99;
    tick();
    ram_ack = 1'b0;
    check("late_ack_din", ioctl_din, 8'h00);
    check("late_ack_wait", ioctl_wait, 1'b0);
    check("late_ack_pause", pause_req, 1'b1);

`ifdef UPLOAD_DIRTY_TRACK_EN
    ioctl_upload = 1'b0;
    tick();
    ram_wr_mon = 1'b1;
    tick();
    ram_wr_mon = 1'b0;
    osd_open   = 1'b1;
    tick();
    check("dirty_upload_pulse", upload_req, 1'b1);
    tick();
    check("dirty_upload_one_cycle", upload_req, 1'b0);
    osd_open = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) read_txn(25'(i), 2, 8'(i + 16), 1'b0);
    ioctl_upload = 1'b0;
    tick();
    tick();
    osd_open = 1'b1;
    tick();
    check("clean_no_pulse0", upload_req, 1'b0);
    tick();
    check("clean_no_pulse1", upload_req, 1'b0);
    osd_open = 1'b0;
`else
    ioctl_upload = 1'b0;
    tick();
    ram_wr_mon = 1'b1;
    tick();
    ram_wr_mon = 1'b0;
    osd_open   = 1'b1;
    tick();
    check("nodirty_upload0", upload_req, 1'b0);
    tick();
    check("nodirty_upload1", upload_req, 1'b0);
    osd_open = 1'b0;
`endif
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ioctl_upload_responder.md
IOCTL_UPLOAD_RESPONDER -- requirements
Module: ioctl_upload_responder

Interface
REQ-001 SHALL have parameter INDEX, default 8'd5, ioctl_index value this block serves.
REQ-002 SHALL have parameter AW, default 13, core RAM address width.
REQ-003 SHALL have parameter SIZE, default 8192, number of valid bytes; SIZE <= 2^AW.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for ram_ack.
REQ-005 Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_upload  in  1  upload active, from hps_io.
- ioctl_index  in  8  file index.
- ioctl_rd  in  1  one-cycle byte read strobe.
- ioctl_addr  in  25  byte address, valid with ioctl_rd.
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_wait  out  1  hold-off to hps_io.
- ram_addr  out  AW  core RAM read address.
- ram_rd  out  1  RAM read request, level.
- ram_ack  in  1  RAM data valid; one cycle.
- ram_data  in  8  RAM read data.
- ram_wr_mon  in  1  core write strobe, dirty-tracking monitor.
- osd_open  in  1  OSD_STATUS.
- pause_req  out  1  freeze core during upload.
- upload_req  out  1  autosave request pulse.
- err  out  1  sticky timeout flag.

Function
REQ-006 "sel" = ioctl_upload && (ioctl_index == INDEX); all responses SHALL be gated by sel.
REQ-007 pause_req SHALL equal sel, registered, one cycle latency.
REQ-008 FSM states: IDLE, ARMED, FETCH, DONE.
REQ-009 IDLE->ARMED on sel rising; any state->IDLE when sel low.
REQ-010 ARMED, ioctl_rd, ioctl_addr < SIZE: latch ram_addr = ioctl_addr[AW-1:0], assert ram_rd and ioctl_wait next cycle, go FETCH.
REQ-011 ARMED, ioctl_rd, ioctl_addr >= SIZE: ioctl_din = 8'hFF next cycle, no ioctl_wait, no RAM access, stay ARMED.
REQ-012 FETCH, ram_ack: ioctl_din <= ram_data, ram_rd and ioctl_wait deassert same edge, go DONE.
REQ-013 FETCH: cycle counter starts at 0 on entry; reaching TIMEOUT without ram_ack: ioctl_din <= 8'h00, err <= 1, ram_rd/ioctl_wait drop, go DONE.
REQ-014 DONE SHALL return to ARMED next cycle; count of bytes served increments (saturating 16-bit, internal).
REQ-015 ioctl_rd in FETCH or DONE SHALL be ignored.
REQ-016 ram_ack outside FETCH SHALL be ignored.
REQ-017 ioctl_din SHALL hold its last value between reads.
REQ-018 Max read latency ioctl_rd -> ioctl_din valid = TIMEOUT+2 cycles; ioctl_wait high exactly during FETCH.
REQ-019 sel falling during FETCH: abort, ram_rd low next cycle, ioctl_wait low, ioctl_din unchanged, err unchanged.

Reset
REQ-020 reset SHALL force: state IDLE, ioctl_din 8'h00, ioctl_wait 0, ram_rd 0, ram_addr 0, pause_req 0, upload_req 0, err 0, counters 0, dirty 0.
REQ-021 reset SHALL take precedence over every simultaneous input including mid-FETCH.
REQ-022 err SHALL clear only on reset.

Configuration
REQ-023 Macro UPLOAD_DIRTY_TRACK_EN compiles in dirty tracking.
REQ-024 With macro: ram_wr_mon sets dirty; osd_open rising edge with dirty=1 and sel=0 pulses upload_req for exactly one cycle.
REQ-025 With macro: dirty clears on sel falling edge if >=1 byte was served in that session; ram_wr_mon on that same cycle keeps dirty=1 (set wins).
REQ-026 Without macro: upload_req tied 0, no dirty register, ram_wr_mon and osd_open unused.

Verification
REQ-027 sel on, ioctl_rd addr 0x0010, ram_ack 3 cycles later with 8'hA5 -> ioctl_wait high 3 cycles, then ioctl_din=8'hA5, ioctl_wait 0.
REQ-028 ioctl_rd addr SIZE (8192) -> ioctl_din=8'hFF next cycle, ram_rd never asserted, ioctl_wait stays 0.
REQ-029 ioctl_rd, ram_ack withheld -> after 255 cycles ioctl_din=8'h00, err=1, ioctl_wait 0; err persists until reset.
REQ-030 reset asserted mid-FETCH -> next cycle all outputs at reset values; later ram_ack ignored.
REQ-031 With UPLOAD_DIRTY_TRACK_EN: ram_wr_mon pulse, osd_open 0->1 -> upload_req one-cycle pulse; upload of 4 bytes, sel falls -> dirty 0; osd_open re-rise -> no pulse.
REQ-032 ioctl_index 8'd4 with ioctl_upload 1 -> pause_req 0, ioctl_rd ignored, ioctl_din unchanged.
